rate_generator: RTL and testbench
=================================

# rate_generator

Parametrised multi-channel rate generator for the reaction-time tester. It derives NUM_CH independent square waves and single-cycle tick strobes from the 12 MHz system clock. Each channel has a half-period divisor that is set at reset and can be reprogrammed at runtime without glitches. It replaces the fixed 1 kHz / 2 Hz divider and feeds the display scan, blink and millisecond-timer logic. Downstream logic uses the tick strobes as clock enables rather than as clocks.

## Interface
- NUM_CH, 2: number of channels, 1..16.
- CNT_W, 24: counter and divisor width.
- RST_HALF, {24'd2_999_999, 24'd5_999}: packed NUM_CH*CNT_W reset divisors, channel 0 in the LSBs. The default gives channel 0 = 1 kHz and channel 1 = 2 Hz.
- CH_W (localparam): max(1, $clog2(NUM_CH)).
- clk_12MHz  in  1  system clock. All logic is on the rising edge.
- rst  in  1  reset. Synchronous and active-high.
- ch_en  in  NUM_CH  per-channel run enable.
- sync  in  1  single-cycle restart of all channels.
- cfg_we  in  1  divisor write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_half  in  CNT_W  new half-period value H.
- sq_out  out  NUM_CH  square wave per channel, registered.
- tick  out  NUM_CH  one-cycle strobe on each sq_out rising edge, registered.
- pend  out  NUM_CH  a written divisor is waiting to take effect.
- cfg_err  out  1  one-cycle pulse when a write targets a channel index of NUM_CH or above.

## Operation
- Per-channel state:
  - cnt[CNT_W]: counter.
  - act[CNT_W]: active divisor.
  - shd[CNT_W]: shadow divisor.
  - pend flag.
  - sq bit.
- Reset: while rst=1 on a clock edge, all channels load cnt=0, act=shd=RST_HALF slice, pend=0, sq_out=0, tick=0 and cfg_err=0. rst overrides every other input.
- Running channel (ch_en=1, no sync):
  - If cnt != act: cnt increments by 1.
  - If cnt == act (terminal count): cnt goes to 0 and sq toggles.
  - tick=1 for exactly the cycle in which sq_out has just gone 0 to 1.
- Resulting output period is 2*(H+1) cycles at a 50% duty cycle. H=0 is legal and gives clk/2 with tick every 2 cycles.
- Disabled channel (ch_en=0): cnt=0, sq_out=0 and tick=0 are forced every cycle. act, shd and pend are retained. On re-enable the channel counts from 0.
- Divisor write (cfg_we=1, cfg_ch < NUM_CH): shd[cfg_ch] takes cfg_half and pend[cfg_ch] goes to 1.
- Divisor apply: at the next terminal count, act takes shd and pend clears. The compare in that terminal cycle uses the old act.
- Write in the same cycle as a terminal count on that channel: the terminal count uses the old act. The new value lands in shd, pend=1, and is applied at the following terminal count.
- Back-to-back writes before an apply: the last write wins. pend stays 1.
- Write to an invalid channel (cfg_ch >= NUM_CH): no state changes, and cfg_err pulses 1 cycle later.
- sync=1: every channel loads cnt=0 and sq=0, with no tick in that cycle. Any pending shd is copied to act and pend clears, including on disabled channels.
- sync and cfg_we in the same cycle: sync is applied first, then the write lands in shd with pend=1.
- No arithmetic overflow is possible: cnt never exceeds act ≤ 2^CNT_W−1.
- Channels are fully independent except for the shared sync and the shared config port.

## Timing
- Latency from reset release (first edge with rst=0, ch_en=1): sq_out rises and tick pulses after edge H+1, counting that first edge as edge 1.
- Every subsequent tick follows 2*(H+1) edges later.
- sq_out and tick update on the same edge. Both are flop outputs with no combinational path from any input.
- A write in cycle t becomes visible on pend at t+1.
- The earliest period change is the half-period that starts after the next terminal count.
- sync in cycle t: sq_out=0 at t+1. The first tick comes after edge t+1+H+1 using the post-sync act.
- A mid-operation rst takes effect on the next edge and discards all pending writes.

## Test plan
- Reset defaults, NUM_CH=2, RST_HALF={24'd9, 24'd2}, ch_en=2'b11:
  - ch0 ticks every 6 cycles, first tick 3 edges after reset release, sq high 3 / low 3.
  - ch1 ticks every 20 cycles, first tick 10 edges after reset release.
- Runtime write of H=4 to ch0 mid-half-period:
  - pend[0]=1 next cycle.
  - The current half-period completes at the old H=2, then the period becomes 10.
  - pend[0] clears on the apply edge.
  - sq_out shows no glitch or short pulse.
- Write coinciding with a terminal count on ch0:
  - The old value is used for the current terminal count.
  - The new value is applied at the following terminal count.
  - Also check H=0, which must give a tick every 2 cycles.
- ch_en[1] toggled low for 7 cycles mid-count:
  - sq_out[1] and tick[1] are 0 throughout.
  - After re-enable, the first tick comes H+1 edges later.
  - ch0 is unaffected.
- sync asserted while ch0 has a pending write:
  - Both sq_out=0 next cycle.
  - The new H takes effect immediately.
  - The first ticks come at H+1 edges after sync.
- cfg_ch=3 with NUM_CH=3: cfg_err pulses one cycle, and act, shd and pend of all channels are unchanged. Assert rst mid-run: all outputs are 0 on the next edge.

Source files
------------

// File: rtl/rate_generator.sv
// Multi-channel rate generator: per-channel square wave and rising-edge tick strobe,
// half-period divisors shadow-buffered so runtime reprogramming never glitches the output.
module rate_generator #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 24,
  parameter logic [NUM_CH*CNT_W-1:0] RST_HALF = {24'd2_999_999, 24'd5_999},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_12MHz,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  output logic [NUM_CH-1:0] sq_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pend,
  output logic              cfg_err
);

  logic cfg_err_q;
  logic cfg_bad;

  // Widened by one bit so the range check still works when NUM_CH is a power of two.
  assign cfg_bad = cfg_we && ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));

  always_ff @(posedge clk_12MHz) begin
    if (rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_bad;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act;
    logic [CNT_W-1:0] shd;
    logic             pend_q;
    logic             sq_q;
    logic             tick_q;
    logic             wr_hit;
    logic             term;

    assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));
    assign term   = (cnt == act);

    always_ff @(posedge clk_12MHz) begin
      if (rst) begin
        cnt    <= '0;
        act    <= RST_HALF[i*CNT_W +: CNT_W];
        shd    <= RST_HALF[i*CNT_W +: CNT_W];
        pend_q <= 1'b0;
        sq_q   <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        if (sync) begin
          cnt    <= '0;
          sq_q   <= 1'b0;
          tick_q <= 1'b0;
          if (pend_q) act <= shd;
          pend_q <= 1'b0;
        end else if (!ch_en[i]) begin
          cnt    <= '0;
          sq_q   <= 1'b0;
          tick_q <= 1'b0;
        end else if (term) begin
          // The compare above used the old act; the shadow only lands for the next half-period.
          cnt    <= '0;
          sq_q   <= ~sq_q;
          tick_q <= ~sq_q;
          if (pend_q) begin
            act    <= shd;
            pend_q <= 1'b0;
          end
        end else begin
          cnt    <= cnt + CNT_W'(1);
          tick_q <= 1'b0;
        end
        // A write is ordered after sync/apply so it always survives as a fresh pending value.
        if (wr_hit) begin
          shd    <= cfg_half;
          pend_q <= 1'b1;
        end
      end
    end

    assign sq_out[i] = sq_q;
    assign tick[i]   = tick_q;
    assign pend[i]   = pend_q;
  end

endmodule

// File: tb/tb_rate_generator.sv
// Bench for rate_generator: directed scenarios then random traffic, all checked
// cycle by cycle against a countdown-based reference model.
module tb_rate_generator;
  localparam int NCH = 3;
  localparam int CW  = 24;
  localparam int RST_H [NCH] = '{2, 9, 5};

  logic           clk_12MHz = 1'b0;
  logic           rst;
  logic [NCH-1:0] ch_en;
  logic           sync;
  logic           cfg_we;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_half;
  logic [NCH-1:0] sq_out, tick, pend;
  logic           cfg_err;

  int total = 0;
  int bad   = 0;

  // Reference model: edges left until next toggle, applied and pending divisors.
  int m_left [NCH];
  int m_act  [NCH];
  int m_shd  [NCH];
  bit m_pend [NCH];
  bit m_sq   [NCH];
  bit m_tick [NCH];
  bit m_err;

  rate_generator #(
    .NUM_CH  (NCH),
    .CNT_W   (CW),
    .RST_HALF({24'd5, 24'd9, 24'd2})
  ) dut (
    .clk_12MHz(clk_12MHz),
    .rst      (rst),
    .ch_en    (ch_en),
    .sync     (sync),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_half (cfg_half),
    .sq_out   (sq_out),
    .tick     (tick),
    .pend     (pend),
    .cfg_err  (cfg_err)
  );

  always #41 clk_12MHz = ~clk_12MHz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      if (rst) begin
        m_act[c] = RST_H[c]; m_shd[c] = RST_H[c]; m_pend[c] = 0;
        m_sq[c] = 0; m_tick[c] = 0; m_left[c] = RST_H[c] + 1;
        continue;
      end
      if (sync) begin
        if (m_pend[c]) m_act[c] = m_shd[c];
        m_pend[c] = 0; m_sq[c] = 0; m_tick[c] = 0;
        m_left[c] = m_act[c] + 1;
      end else if (!ch_en[c]) begin
        m_sq[c] = 0; m_tick[c] = 0;
        m_left[c] = m_act[c] + 1;
      end else begin
        m_left[c]--;
        m_tick[c] = 0;
        if (m_left[c] == 0) begin
          m_sq[c] = !m_sq[c];
          m_tick[c] = m_sq[c];
          if (m_pend[c]) begin m_act[c] = m_shd[c]; m_pend[c] = 0; end
          m_left[c] = m_act[c] + 1;
        end
      end
      if (cfg_we && int'(cfg_ch) == c) begin
        m_shd[c] = int'(cfg_half); m_pend[c] = 1;
      end
    end
    m_err = !rst && cfg_we && (int'(cfg_ch) >= NCH);
  endtask

  task automatic compare();
    logic [NCH-1:0] e_sq, e_tick, e_pend;
    e_sq = '0; e_tick = '0; e_pend = '0;
    for (int c = 0; c < NCH; c++) begin
      e_sq[c] = m_sq[c]; e_tick[c] = m_tick[c]; e_pend[c] = m_pend[c];
    end
    chk("sq_out", 32'(sq_out), 32'(e_sq));
    chk("tick", 32'(tick), 32'(e_tick));
    chk("pend", 32'(pend), 32'(e_pend));
    chk("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk_12MHz);
    model_edge();
    @(negedge clk_12MHz);
    compare();
    rst = 0; sync = 0; cfg_we = 0;
  endtask

  task automatic wr(input int ch, input int h);
    cfg_we = 1; cfg_ch = 2'(ch); cfg_half = CW'(h);
  endtask

  initial begin
    int f0, s0, f1, n, guard;
    rst = 1; ch_en = 3'b111; sync = 0; cfg_we = 0; cfg_ch = 0; cfg_half = 0;
    @(negedge clk_12MHz);
    rst = 1; step();
    rst = 1; step();
    chk("reset_sq", 32'(sq_out), 0);
    chk("reset_tick", 32'(tick), 0);

    // Reset release: first-tick latency and ch0 period from fixed expectations.
    f0 = 0; s0 = 0; f1 = 0;
    for (n = 1; n <= 24; n++) begin
      step();
      if (tick[0] && f0 == 0) f0 = n;
      else if (tick[0] && s0 == 0) s0 = n;
      if (tick[1] && f1 == 0) f1 = n;
    end
    chk("first_tick_ch0", f0, 3);
    chk("second_tick_ch0", s0, 9);
    chk("first_tick_ch1", f1, 10);

    // Runtime write of H=4 to ch0 mid-half-period.
    guard = 0;
    while (m_left[0] != 2 && guard < 50) begin step(); guard++; end
    wr(0, 4); step();
    chk("pend_after_write", 32'(pend[0]), 1);
    repeat (30) step();

    // Write H=0 landing on a ch0 terminal-count edge.
    guard = 0;
    while (m_left[0] != 1 && guard < 50) begin step(); guard++; end
    chk("tc_align_guard", (guard < 50) ? 1 : 0, 1);
    wr(0, 0); step();
    repeat (20) step();

    // ch1 disabled for 7 cycles mid-count.
    repeat (4) step();
    ch_en = 3'b101;
    for (int k = 0; k < 7; k++) begin step(); ch_en = 3'b101; end
    ch_en = 3'b111;
    repeat (25) step();

    // sync while ch0 has a pending write.
    wr(0, 3); step();
    sync = 1; step();
    chk("sync_sq_clear", 32'(sq_out), 0);
    repeat (20) step();

    // Write to out-of-range channel.
    wr(3, 7); step();
    chk("cfg_err_pulse", 32'(cfg_err), 1);
    step();
    chk("cfg_err_clear", 32'(cfg_err), 0);
    repeat (12) step();

    // Mid-run reset with a write pending.
    wr(1, 1); step();
    rst = 1; step();
    chk("midrun_rst_sq", 32'(sq_out), 0);
    chk("midrun_rst_pend", 32'(pend), 0);
    repeat (10) step();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      ch_en = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b111;
      sync  = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) wr($urandom_range(0, 3), $urandom_range(0, 6));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
